// File: rtl/seq_divider.sv
// Iterative restoring divider producing one quotient bit per cycle.
// It supports signed and unsigned operands and reports divide-by-zero and signed overflow.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero,
  output logic             Overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem, dvd, dsr;
  logic               sgn, a_neg, b_neg, ovf_pend;
  logic               accept;

  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               qbit;
  logic [WIDTH-1:0]   rem_nxt, dvd_nxt;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (s && sv < 0) ? -sv : sv;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  // The trial subtract gets two extra bits, so its borrow is exact even when the shifted remainder reaches 2^WIDTH.
  assign shifted = {rem, dvd[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dsr};
  assign qbit    = ~trial[WIDTH+1];
  assign rem_nxt = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_nxt = {dvd[WIDTH-2:0], qbit};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (B == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and visible results
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= CNT_W'(WIDTH - 1);
        DivZero  <= (B == '0);
        Overflow <= 1'b0;
        if (B == '0) begin
          Quotient  <= '1;
          Remainder <= A;
        end
      end else if (state == RUN) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          Quotient  <= apply_sign(dvd_nxt, sgn & (a_neg ^ b_neg));
          Remainder <= apply_sign(rem_nxt, sgn & a_neg);
          Overflow  <= ovf_pend;
        end
      end
    end
  end

  // Iteration datapath, loaded on accept and shifted while running
  always_ff @(posedge clk) begin
    if (accept) begin
      sgn      <= Sign;
      a_neg    <= A[WIDTH-1];
      b_neg    <= B[WIDTH-1];
      ovf_pend <= Sign && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
      rem      <= '0;
      dvd      <= mag(A, Sign);
      dsr      <= mag(B, Sign);
    end else if (state == RUN) begin
      rem <= rem_nxt;
      dvd <= dvd_nxt;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider.
// An arithmetic reference model feeds a scoreboard queue that a done-driven monitor drains.
module tb_seq_divider;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start, Sign;
  logic [W-1:0]  A, B;
  logic          busy, done, DivZero, Overflow;
  logic [W-1:0]  Quotient, Remainder;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .Sign(Sign), .A(A), .B(B),
    .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder),
    .DivZero(DivZero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division on 64-bit values; at = cycle count when done must show.
  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int at);
    exp_t e;
    longint na, nb;
    e.at = at;
    e.dz = (b == 0);
    e.ov = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else begin
      if (s) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'd0, a});
        nb = longint'({32'd0, b});
      end
      e.q = W'(na / nb);
      e.r = W'(na % nb);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", Quotient, mon_e.q);
        check("remainder", Remainder, mon_e.r);
        check("divzero", W'(DivZero), W'(mon_e.dz));
        check("overflow", W'(Overflow), W'(mon_e.ov));
        check("done_cycle", W'(cyc), W'(mon_e.at));
        check("busy_in_done", W'(busy), 32'd0);
      end
    end
  end

  // Start is accepted one edge after it is driven; done shows WIDTH edges after that (or at once when B == 0).
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    Sign  = s;
    A     = a;
    B     = b;
    start = 1'b1;
    sb.push_back(model(s, a, b, cyc + 1 + ((b == 0) ? 0 : W)));
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    Sign  = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (n < W + 8 && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    check("done_seen", W'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         seen;
    reset = 1'b1; start = 1'b0; Sign = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), 32'd0);
    check("rst_done", W'(done), 32'd0);
    check("rst_q", Quotient, 32'd0);
    check("rst_r", Remainder, 32'd0);
    check("rst_flags", W'({DivZero, Overflow}), 32'd0);
    reset = 1'b0;

    launch(1'b0, 32'd100, 32'd7);                 wait_done();
    launch(1'b1, -32'sd7, 32'd2);                 wait_done();
    launch(1'b1, 32'd7, -32'sd2);                 wait_done();
    launch(1'b0, 32'h1234, 32'd0);                wait_done();
    launch(1'b1, 32'h1234, 32'd0);                wait_done();
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done();
    launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done();
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   wait_done();
    launch(1'b1, 32'h8000_0000, 32'd1);           wait_done();

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 + $urandom_range(0, 2) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 5)) : $urandom;
      if ($urandom_range(0, 4) == 0) rb = -rb;
      launch(1'($urandom), ra, rb);
      wait_done();
    end

    // Start held high: only the operands present at each accept count, accepts W+2 cycles apart.
    @(posedge clk);
    #1;
    Sign = 1'b0; A = 32'd1000; B = 32'd10; start = 1'b1;
    sb.push_back(model(1'b0, 32'd1000, 32'd10, cyc + 1 + W));
    sb.push_back(model(1'b1, -32'sd77, 32'd5, cyc + 1 + W + (W + 2)));
    @(posedge clk);
    #1;
    Sign = 1'b1; A = -32'sd77; B = 32'd5;
    wait_done();
    wait_done();
    start = 1'b0;

    // Reset in the middle of an iteration discards it.
    launch(1'b0, 32'hFFFF_FFFF, 32'd3);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    check("midrst_busy", W'(busy), 32'd0);
    check("midrst_q", Quotient, 32'd0);
    check("midrst_r", Remainder, 32'd0);
    check("midrst_flags", W'({done, DivZero, Overflow}), 32'd0);
    seen = 1'b0;
    repeat (W + 6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", W'(seen), 32'd0);
    launch(1'b0, 32'd9, 32'd3);
    wait_done();

    repeat (2) @(posedge clk);
    check("scoreboard_empty", W'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
